// File: rtl/emu_ctrl_pkg.sv
// Shared definitions for the emulation run-control block: counter width
// default and the counter type used by the host-facing registers.
package emu_ctrl_pkg;

    // Default width of the cycle counter and the step budget counter.
    localparam int CNT_W_DEFAULT = 64;

    // Counter value at the default width.
    typedef logic [CNT_W_DEFAULT-1:0] cnt_t;

endpackage

// File: rtl/clock_gate_if.sv
// Host command/status bundle for the emulation clock gate.
//
// Command semantics: every host command (pause_req, resume_req,
// count_write, step_write) is a level sampled on each rising clk edge,
// so holding it high for one cycle issues it once. There is no
// back-pressure; a command is always accepted on the edge at which it
// is high. Status outputs (pause, count) are registered; step_trig is
// combinational and valid for the current cycle only.
interface clock_gate_if #(
    parameter int CNT_W = emu_ctrl_pkg::CNT_W_DEFAULT
);
    logic             pause_req;
    logic             resume_req;
    logic             count_write;
    logic [CNT_W-1:0] count_wdata;
    logic             step_write;
    logic [CNT_W-1:0] step_wdata;
    logic             pause;
    logic [CNT_W-1:0] count;
    logic             step_trig;

    // Host side: issues commands, observes status.
    modport master (
        output pause_req, resume_req, count_write, count_wdata,
               step_write, step_wdata,
        input  pause, count, step_trig
    );

    // Clock gate side: receives commands, drives status.
    modport slave (
        input  pause_req, resume_req, count_write, count_wdata,
               step_write, step_wdata,
        output pause, count, step_trig
    );
endinterface

// File: rtl/cg_cell.sv
// Glitch-free clock gating cell: low-phase transparent latch on the
// enable, ANDed with the clock. An enable that is settled before a rising
// edge produces exactly that one high pulse; the latch holds it steady
// while clk is high, so enable changes mid-pulse cannot chop the clock.
module cg_cell (
    input  logic clk,
    input  logic en,
    output logic gclk
);
    logic en_l;

    // Capture the enable only while clk is low.
    always_latch begin
        if (!clk) begin
            en_l <= en;
        end
    end

    assign gclk = clk & en_l;
endmodule

// File: rtl/clock_gate.sv
// Emulation run control: decides each cycle whether the emulated DUT
// advances, gates the DUT / flip-flop scan / RAM scan clocks, counts
// executed DUT cycles and enforces a host-programmed step budget that
// pauses emulation when it runs out.
import emu_ctrl_pkg::*;

module clock_gate #(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         trig,
    input  logic         stall,
    input  logic         ff_scan,
    input  logic         ram_scan,
    clock_gate_if.slave  host,
    output logic         run,
    output logic         dut_clk,
    output logic         ff_clk,
    output logic         ram_clk
);
    logic             pause_q;
    logic             pause_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] step_q;
    logic [CNT_W-1:0] step_d;   // the "step_next" value
    logic             step_trig;
    logic             ff_en;
    logic             ram_en;

    // Run decision, clock enables, next-state for counter, step budget and pause.
    always_comb begin
        run    = !pause_q && !stall;
        ff_en  = run || ff_scan;
        ram_en = run || ram_scan;

        // Host overwrite beats the running increment; wraps at 2^CNT_W.
        count_d = count_q;
        if (host.count_write) begin
            count_d = host.count_wdata;
        end else if (run) begin
            count_d = count_q + CNT_W'(1);
        end

        // An exhausted budget stays at zero rather than wrapping.
        step_d = step_q;
        if (host.step_write) begin
            step_d = host.step_wdata;
        end else if (step_q == '0) begin
            step_d = '0;
        end else if (run) begin
            step_d = step_q - CNT_W'(1);
        end

        // Fires on the nonzero -> zero transition, including a host load of 0.
        step_trig = (step_q != '0) && (step_d == '0);

        // Any pause source beats a simultaneous resume.
        pause_d = pause_q;
        if (trig || step_trig || host.pause_req) begin
            pause_d = 1'b1;
        end else if (host.resume_req) begin
            pause_d = 1'b0;
        end
    end

    // Registered state; synchronous reset overrides every host command.
    always_ff @(posedge clk) begin
        if (rst) begin
            pause_q <= 1'b0;
            count_q <= '0;
            step_q  <= '0;
        end else begin
            pause_q <= pause_d;
            count_q <= count_d;
            step_q  <= step_d;
        end
    end

    assign host.pause     = pause_q;
    assign host.count     = count_q;
    assign host.step_trig = step_trig;

    // Gating is not forced off during reset so the DUT sees its reset edges.
    cg_cell u_cg_dut (.clk(clk), .en(run),    .gclk(dut_clk));
    cg_cell u_cg_ff  (.clk(clk), .en(ff_en),  .gclk(ff_clk));
    cg_cell u_cg_ram (.clk(clk), .en(ram_en), .gclk(ram_clk));
endmodule

// File: tb/tb_clock_gate.sv
// Bench for clock_gate: hand-computed vector table, directed multi-cycle
// sequences and randomized stimulus against a cycle-level reference model.
module tb_clock_gate;
    import emu_ctrl_pkg::*;

    typedef struct {
        bit   rst;
        bit   trig;
        bit   stall;
        bit   pause_req;
        bit   resume_req;
        bit   ff_scan;
        bit   ram_scan;
        bit   count_write;
        cnt_t count_wdata;
        bit   step_write;
        cnt_t step_wdata;
    } in_t;

    typedef struct {
        in_t  in;
        cnt_t exp_count;
        bit   exp_pause;
    } vec_t;

    logic clk;
    logic rst;
    logic trig;
    logic stall;
    logic ff_scan;
    logic ram_scan;
    logic run;
    logic dut_clk;
    logic ff_clk;
    logic ram_clk;

    clock_gate_if hif ();

    clock_gate dut (
        .clk(clk), .rst(rst), .trig(trig), .stall(stall),
        .ff_scan(ff_scan), .ram_scan(ram_scan), .host(hif),
        .run(run), .dut_clk(dut_clk), .ff_clk(ff_clk), .ram_clk(ram_clk)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pulse counters on the gated clocks
    int n_dut = 0;
    int n_ff  = 0;
    int n_ram = 0;
    always @(posedge dut_clk) n_dut = n_dut + 1;
    always @(posedge ff_clk)  n_ff  = n_ff + 1;
    always @(posedge ram_clk) n_ram = n_ram + 1;

    // scoreboard counters
    int n_vec = 0;
    int n_bad = 0;

    // reference model state
    cnt_t m_count;
    cnt_t m_step;
    bit   m_pause;
    logic obs_trig;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t mk(bit t, bit st, bit pr, bit rr, bit cw, cnt_t cwd, bit sw, cnt_t swd);
        in_t v;
        v.rst = 1'b0; v.trig = t; v.stall = st; v.pause_req = pr; v.resume_req = rr;
        v.ff_scan = 1'b0; v.ram_scan = 1'b0;
        v.count_write = cw; v.count_wdata = cwd; v.step_write = sw; v.step_wdata = swd;
        return v;
    endfunction

    function automatic in_t idle();
        return mk(0, 0, 0, 0, 0, '0, 0, '0);
    endfunction

    // Budget remaining after this cycle, straight from the budget rules.
    function automatic cnt_t ref_budget(in_t v, bit advancing);
        if (v.step_write) return v.step_wdata;
        if (m_step == 0)  return 0;
        return advancing ? m_step - 1 : m_step;
    endfunction

    // driver: one full clock cycle, entered and left just after a falling edge
    task automatic apply(input in_t v);
        bit   exp_run;
        bit   exp_trig;
        bit   e_ff;
        bit   e_ram;
        cnt_t nb;
        int   d0, f0, r0;
        rst = v.rst; trig = v.trig; stall = v.stall;
        ff_scan = v.ff_scan; ram_scan = v.ram_scan;
        hif.pause_req = v.pause_req; hif.resume_req = v.resume_req;
        hif.count_write = v.count_write; hif.count_wdata = v.count_wdata;
        hif.step_write = v.step_write; hif.step_wdata = v.step_wdata;
        #2;
        exp_run  = !m_pause && !v.stall;
        e_ff     = exp_run || v.ff_scan;
        e_ram    = exp_run || v.ram_scan;
        nb       = ref_budget(v, exp_run);
        exp_trig = (m_step != 0) && (nb == 0);
        obs_trig = hif.step_trig;
        check("run", {63'd0, run}, {63'd0, exp_run});
        check("step_trig", {63'd0, hif.step_trig}, {63'd0, exp_trig});
        check("pause", {63'd0, hif.pause}, {63'd0, m_pause});
        check("count", hif.count, m_count);
        d0 = n_dut; f0 = n_ff; r0 = n_ram;
        @(posedge clk);
        if (v.rst) begin
            m_count = 0; m_step = 0; m_pause = 0;
        end else begin
            if (v.count_write) m_count = v.count_wdata;
            else if (exp_run)  m_count = m_count + 1;
            m_step = nb;
            if (v.trig || exp_trig || v.pause_req) m_pause = 1;
            else if (v.resume_req)                 m_pause = 0;
        end
        #1;
        check("gclk_high", {61'd0, dut_clk, ff_clk, ram_clk}, {61'd0, exp_run, e_ff, e_ram});
        @(negedge clk);
        #1;
        check("gclk_low", {61'd0, dut_clk, ff_clk, ram_clk}, 64'd0);
        check("pulse_cnt", {32'd0, 8'(n_dut - d0), 8'(n_ff - f0), 8'(n_ram - r0)},
              {32'd0, 8'(exp_run), 8'(e_ff), 8'(e_ram)});
    endtask

    vec_t tbl[16];
    in_t  v;
    cnt_t c0;
    int   b_dut, b_ff, b_ram;
    bit   pat[8];

    initial begin
        rst = 1'b1; trig = 0; stall = 0; ff_scan = 0; ram_scan = 0;
        hif.pause_req = 0; hif.resume_req = 0; hif.count_write = 0; hif.count_wdata = '0;
        hif.step_write = 0; hif.step_wdata = '0;
        m_count = 0; m_step = 0; m_pause = 0;
        // settle state out of X before any checking
        @(posedge clk);
        @(negedge clk);
        #1;

        // reset, then 10 free-running cycles
        v = idle(); v.rst = 1; apply(v);
        check("reset_count", hif.count, 64'd0);
        check("reset_pause", {63'd0, hif.pause}, 64'd0);
        b_dut = n_dut; b_ff = n_ff; b_ram = n_ram;
        for (int i = 0; i < 10; i++) apply(idle());
        check("free_count", hif.count, 64'd10);
        check("free_pulses", {16'd0, 16'(n_dut - b_dut), 16'(n_ff - b_ff), 16'(n_ram - b_ram)},
              {16'd0, 16'd10, 16'd10, 16'd10});

        // table of hand-computed post-edge values, starting from a fresh reset
        v = idle(); v.rst = 1; apply(v);
        tbl[0]  = '{mk(0,0,0,0,0,'0,0,'0), 64'd1, 0};
        tbl[1]  = '{mk(0,1,0,0,0,'0,0,'0), 64'd1, 0};
        tbl[2]  = '{mk(0,0,0,0,1,64'h1234,0,'0), 64'h1234, 0};
        tbl[3]  = '{mk(0,0,0,0,0,'0,0,'0), 64'h1235, 0};
        tbl[4]  = '{mk(0,0,1,1,0,'0,0,'0), 64'h1236, 1};
        tbl[5]  = '{mk(0,0,0,0,0,'0,0,'0), 64'h1236, 1};
        tbl[6]  = '{mk(0,0,0,1,0,'0,0,'0), 64'h1236, 0};
        tbl[7]  = '{mk(1,0,0,0,0,'0,0,'0), 64'h1237, 1};
        tbl[8]  = '{mk(0,0,0,1,0,'0,0,'0), 64'h1237, 0};
        tbl[9]  = '{mk(0,0,0,0,0,'0,1,64'd0), 64'h1238, 0};
        tbl[10] = '{mk(0,1,0,1,0,'0,0,'0), 64'h1238, 0};
        tbl[11] = '{mk(0,0,0,0,1,64'hFFFF_FFFF_FFFF_FFFF,0,'0), 64'hFFFF_FFFF_FFFF_FFFF, 0};
        tbl[12] = '{mk(0,0,0,0,0,'0,0,'0), 64'd0, 0};
        tbl[13] = '{mk(0,1,0,0,0,'0,1,64'd3), 64'd0, 0};
        tbl[14] = '{mk(0,0,0,0,0,'0,1,64'd0), 64'd1, 1};
        tbl[15] = '{mk(0,0,0,0,0,'0,0,'0), 64'd1, 1};
        for (int i = 0; i < 16; i++) begin
            apply(tbl[i].in);
            check($sformatf("tbl%0d_count", i), hif.count, tbl[i].exp_count);
            check($sformatf("tbl%0d_pause", i), {63'd0, hif.pause}, {63'd0, tbl[i].exp_pause});
        end

        // step budget of 5: trigger in the 5th enabled cycle, then paused
        apply(mk(0,1,0,1,0,'0,0,'0));
        apply(mk(0,1,0,0,0,'0,1,64'd5));
        c0 = hif.count;
        for (int i = 0; i < 5; i++) begin
            apply(idle());
            check($sformatf("step5_trig%0d", i), {63'd0, obs_trig}, {63'd0, (i == 4)});
        end
        check("step5_pause", {63'd0, hif.pause}, 64'd1);
        check("step5_count", hif.count, c0 + 64'd5);
        apply(idle());
        check("step5_frozen", hif.count, c0 + 64'd5);

        // stall 3 of 8 cycles
        apply(mk(0,1,0,1,0,'0,0,'0));
        c0 = hif.count; b_dut = n_dut;
        pat = '{1, 0, 0, 1, 0, 1, 0, 0};
        for (int i = 0; i < 8; i++) apply(mk(0,pat[i],0,0,0,'0,0,'0));
        check("stall_count", hif.count, c0 + 64'd5);
        check("stall_dut_pulses", 64'(n_dut - b_dut), 64'd5);

        // paused flip-flop scan: only ff_clk pulses
        apply(mk(0,0,1,0,0,'0,0,'0));
        c0 = hif.count; b_dut = n_dut; b_ff = n_ff; b_ram = n_ram;
        for (int i = 0; i < 4; i++) begin
            v = idle(); v.ff_scan = 1; apply(v);
        end
        check("scan_pulses", {16'd0, 16'(n_dut - b_dut), 16'(n_ff - b_ff), 16'(n_ram - b_ram)},
              {16'd0, 16'd0, 16'd4, 16'd0});
        check("scan_count", hif.count, c0);

        // reset mid-step while paused with budget 7
        apply(mk(0,0,0,0,0,'0,1,64'd7));
        v = idle(); v.rst = 1; apply(v);
        check("rst_step_trig", {63'd0, obs_trig}, 64'd0);
        check("rst_count", hif.count, 64'd0);
        check("rst_pause", {63'd0, hif.pause}, 64'd0);
        for (int i = 0; i < 10; i++) begin
            apply(idle());
            check("post_rst_no_trig", {63'd0, obs_trig}, 64'd0);
        end
        check("post_rst_count", hif.count, 64'd10);

        // randomized stimulus against the reference model
        for (int i = 0; i < 400; i++) begin
            v = idle();
            v.rst         = ($urandom_range(0, 49) == 0);
            v.trig        = ($urandom_range(0, 19) == 0);
            v.stall       = ($urandom_range(0, 3) == 0);
            v.pause_req   = ($urandom_range(0, 15) == 0);
            v.resume_req  = ($urandom_range(0, 3) == 0);
            v.ff_scan     = ($urandom_range(0, 2) == 0);
            v.ram_scan    = ($urandom_range(0, 2) == 0);
            v.count_write = ($urandom_range(0, 29) == 0);
            v.count_wdata = ($urandom_range(0, 1) == 0) ? 64'hFFFF_FFFF_FFFF_FFFE : {$urandom, $urandom};
            v.step_write  = ($urandom_range(0, 9) == 0);
            v.step_wdata  = 64'($urandom_range(0, 12));
            apply(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/clock_gate.md
CLOCK_GATE -- requirements
Module: clock_gate

Interface
REQ-001 SHALL have parameter CNT_W, default 64, the width of the cycle counter and the step counter.
REQ-002 SHALL have port clk, input, 1 bit: free-running emulation clock.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port trig, input, 1 bit: DUT breakpoint/trigger event.
REQ-005 SHALL have port stall, input, 1 bit: DUT must not advance this cycle (memory model busy).
REQ-006 SHALL have ports pause_req and resume_req, inputs, 1 bit each: host pause and resume commands.
REQ-007 SHALL have ports ff_scan and ram_scan, inputs, 1 bit each: flip-flop and RAM scan-chain shift active.
REQ-008 SHALL have ports count_write (input, 1 bit) and count_wdata (input, CNT_W bits): host overwrite of the cycle counter.
REQ-009 SHALL have ports step_write (input, 1 bit) and step_wdata (input, CNT_W bits): host load of the step budget.
REQ-010 SHALL have port pause, output, 1 bit: emulation paused (registered).
REQ-011 SHALL have port run, output, 1 bit: DUT clock enable this cycle.
REQ-012 SHALL have ports dut_clk, ff_clk and ram_clk, outputs, 1 bit each: gated clocks.
REQ-013 SHALL have port count, output, CNT_W bits: DUT cycles executed (registered).
REQ-014 SHALL have port step_trig, output, 1 bit: step budget expires this cycle (combinational).

Function
REQ-015 SHALL compute run = !pause && !stall, combinationally.
REQ-016 SHALL use these clock enables: dut_clk = run; ff_clk = run || ff_scan; ram_clk = run || ram_scan.
REQ-017 SHALL gate each clock glitch-free: the enable is captured by a latch that is transparent while clk is low; gated clock = clk AND latched enable. An enable valid at a rising clk edge produces exactly that one high pulse.
REQ-018 SHALL hold each gated clock low for the whole cycle when its enable is 0, with no partial pulses.
REQ-019 SHALL update count with this priority: count_write loads count_wdata; else run increments count by 1 modulo 2^CNT_W; else count holds.
REQ-020 SHALL compute step_next with this priority: step_write gives step_wdata; else step==0 gives 0; else run gives step-1; else step holds.
REQ-021 SHALL register step <= step_next every cycle.
REQ-022 SHALL compute step_trig = (step != 0) && (step_next == 0), including when step_write loads 0 over a nonzero step.
REQ-023 SHALL update pause with this priority: trig, step_trig or pause_req sets pause to 1 (set wins over resume_req); else resume_req clears pause to 0; else pause holds.
REQ-024 SHALL apply simultaneous stall and pause as run=0: no count increment and no step decrement.
REQ-025 SHALL, while scan is active with pause=1, pulse only the corresponding scan clock; count and step stay frozen.

Reset
REQ-026 SHALL, on a rising clk edge with rst=1, set pause=0, count=0 and step=0, overriding count_write, step_write and all pause sources.
REQ-027 SHALL NOT force gating during reset; clocks follow REQ-016, so the DUT receives reset edges.
REQ-028 SHALL have no asynchronous reset on any state.

Structure
REQ-029 SHALL place CNT_W's default and a cnt_t typedef in shared package emu_ctrl_pkg.
REQ-030 SHALL implement the latch-plus-AND cell once, as sub-module cg_cell (ports clk, en, gclk), instantiated three times.
REQ-031 SHALL have a total RTL size of roughly 120-200 lines.

Verification
REQ-032 Reset, then 10 free cycles with stall=0 -> count=10; dut_clk, ff_clk and ram_clk each give 10 pulses.
REQ-033 step_write with step_wdata=5, then run -> step_trig high in the 5th enabled cycle; pause=1 on the next edge; count advances by exactly 5.
REQ-034 stall=1 for 3 of 8 cycles -> count +5; no dut_clk pulses in stalled cycles; no glitches on any clock.
REQ-035 pause=1 with ff_scan=1 for 4 cycles -> 4 ff_clk pulses; 0 pulses on dut_clk and ram_clk; count unchanged.
REQ-036 pause_req and resume_req in the same cycle -> pause=1; count_write with 0x1234 while running -> count=0x1234, then 0x1235 next cycle.
REQ-037 rst asserted mid-step with step=7 and pause=1 -> step=0, count=0, pause=0; step_trig stays low.
